gamma_lut_interp: RTL

- Parametrised successor to the fixed 3-stage gamma pipeline.
- Applies a per-channel, runtime-programmable gamma curve to N packed channels.
- Uses linear interpolation between LUT knots, so the full input precision is used instead of truncating to the index bits.
- Sits between colour correction and output packing; carries a sideband AUX word through unchanged, with valid/ready backpressure.

---
 rtl/gamma_lut_interp.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gamma_lut_interp.sv
// gamma_lut_interp: per-channel programmable gamma curve with linear interpolation
// between LUT knots; sideband aux and per-pixel bypass travel with each pixel.
// Latency 3 register stages, 1 pixel/clk; global stall, in_ready = !out_valid || out_ready.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     upstream pixel handshake, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_aux, in_bypass             sideband word and per-pixel passthrough flag
//   out_valid/out_ready/out_data  downstream pixel handshake, same packing as in_data
//   out_aux                       sideband aligned with out_data
//   cfg_we/cfg_ch/cfg_addr/cfg_wdata  knot write port, always accepted
module gamma_lut_interp #(
   parameter int DATA_WIDTH = 12,
   parameter int CHANNELS   = 3,
   parameter int IDX_BITS   = 8,
   parameter int AUX_WIDTH  = 36,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
   input  logic [AUX_WIDTH-1:0]           in_aux,
   input  logic                           in_bypass,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
   output logic [AUX_WIDTH-1:0]           out_aux,
   input  logic                           cfg_we,
   input  logic [CH_W-1:0]                cfg_ch,
   input  logic [IDX_BITS:0]              cfg_addr,
   input  logic [DATA_WIDTH-1:0]          cfg_wdata
);

   localparam int FRAC_BITS = DATA_WIDTH - IDX_BITS;
   localparam int KNOTS     = (1 << IDX_BITS) + 1;
   localparam int PW        = DATA_WIDTH + FRAC_BITS + 2;  // signed diff * unsigned frac
   localparam int SW        = DATA_WIDTH + 3;              // knot + shifted product, with sign
   localparam logic signed [SW-1:0] YMAX = SW'((1 << DATA_WIDTH) - 1);

   // Knots are stored XORed with the identity curve, so an all-zero array
   // (the power-up state) reads back as identity and no init sequence is needed.
   logic [DATA_WIDTH-1:0] lut [CHANNELS][KNOTS];

   function automatic logic [DATA_WIDTH-1:0] ident(input logic [IDX_BITS:0] a);
      // The only legal address with the MSB set is the top knot, which saturates.
      if (a[IDX_BITS]) return '1;
      return {a[IDX_BITS-1:0], {FRAC_BITS{1'b0}}};
   endfunction

   logic advance;
   logic cfg_ok;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign cfg_ok   = cfg_we
                   && (!cfg_addr[IDX_BITS] || (cfg_addr[IDX_BITS-1:0] == '0))
                   && (32'(cfg_ch) < CHANNELS);

   // Write port: a read issued on the same edge sees the old knot.
   always_ff @(posedge clk) begin
      if (cfg_ok) lut[cfg_ch][cfg_addr] <= cfg_wdata ^ ident(cfg_addr);
   end

   // Stage 1: knot addresses from the incoming sample
   logic [IDX_BITS:0] rd_a0 [CHANNELS];
   logic [IDX_BITS:0] rd_a1 [CHANNELS];

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         rd_a0[c] = {1'b0, in_data[c*DATA_WIDTH + FRAC_BITS +: IDX_BITS]};
         // Top segment reads knot 2^IDX_BITS, which exists, so no wrap is possible.
         rd_a1[c] = rd_a0[c] + (IDX_BITS+1)'(1);
      end
   end

   logic                           s1_vld, s2_vld;
   logic                           s1_byp, s2_byp;
   logic [CHANNELS*DATA_WIDTH-1:0] s1_data, s2_data;
   logic [AUX_WIDTH-1:0]           s1_aux, s2_aux;
   logic [FRAC_BITS-1:0]           s1_frac [CHANNELS];
   logic [DATA_WIDTH-1:0]          s1_k0   [CHANNELS];
   logic [DATA_WIDTH-1:0]          s1_k1   [CHANNELS];
   logic [DATA_WIDTH-1:0]          s2_k0   [CHANNELS];
   logic signed [PW-1:0]           s2_prod [CHANNELS];

   // Stage 2 combinational: signed slope times fraction
   logic signed [DATA_WIDTH:0]     diff    [CHANNELS];
   logic signed [PW-1:0]           prod    [CHANNELS];

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         diff[c] = $signed({1'b0, s1_k1[c]}) - $signed({1'b0, s1_k0[c]});
         prod[c] = PW'(diff[c]) * PW'($signed({1'b0, s1_frac[c]}));
      end
   end

   // Stage 3 combinational: add, floor via arithmetic shift, clamp
   logic signed [PW-1:0]           shifted [CHANNELS];
   logic signed [SW-1:0]           sum     [CHANNELS];
   logic [CHANNELS*DATA_WIDTH-1:0] y_all;

   always_comb begin
      y_all = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         shifted[c] = s2_prod[c] >>> FRAC_BITS;
         sum[c]     = SW'(shifted[c]) + SW'($signed({1'b0, s2_k0[c]}));
         if (s2_byp)
            y_all[c*DATA_WIDTH +: DATA_WIDTH] = s2_data[c*DATA_WIDTH +: DATA_WIDTH];
         else if (sum[c] < 0)
            y_all[c*DATA_WIDTH +: DATA_WIDTH] = '0;
         else if (sum[c] > YMAX)
            y_all[c*DATA_WIDTH +: DATA_WIDTH] = '1;
         else
            y_all[c*DATA_WIDTH +: DATA_WIDTH] = sum[c][DATA_WIDTH-1:0];
      end
   end

   // Datapath registers that need no reset (qualified by the stage valids)
   always_ff @(posedge clk) begin
      if (advance) begin
         s1_data <= in_data;
         s1_aux  <= in_aux;
         s1_byp  <= in_bypass;
         s2_data <= s1_data;
         s2_aux  <= s1_aux;
         s2_byp  <= s1_byp;
         for (int c = 0; c < CHANNELS; c++) begin
            s1_frac[c] <= in_data[c*DATA_WIDTH +: FRAC_BITS];
            s1_k0[c]   <= lut[c][rd_a0[c]] ^ ident(rd_a0[c]);
            s1_k1[c]   <= lut[c][rd_a1[c]] ^ ident(rd_a1[c]);
            s2_k0[c]   <= s1_k0[c];
            s2_prod[c] <= prod[c];
         end
      end
   end

   // Valid chain and output registers; bubbles shift through like pixels.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s2_vld    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_aux   <= '0;
      end else if (advance) begin
         s1_vld    <= in_valid;
         s2_vld    <= s1_vld;
         out_valid <= s2_vld;
         out_data  <= y_all;
         out_aux   <= s2_aux;
      end
   end

endmodule
